alarm_ring_ctrl: RTL



---
 rtl/alarm_ring_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencer: detects the alarm minute, runs ring/snooze timing and
// produces the LED flash enable plus the blink square wave.
module alarm_ring_ctrl #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3,
  parameter int unsigned BLINK_HALF  = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  input  logic [7:0] alm_hour,
  input  logic [7:0] alm_min,
  input  logic       alm_on,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       en,
  output logic       clk_2,
  output logic       ringing,
  output logic       snoozing
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
  localparam logic [1:0] ST_SNOOZE = 2'd2;

  localparam logic [7:0]  RING_INIT  = RING_SECS[7:0];
  localparam logic [9:0]  SNZ_INIT   = SNOOZE_SECS[9:0];
  localparam logic [2:0]  SNZ_MAX    = MAX_SNOOZE[2:0];
  localparam logic [24:0] BLINK_LAST = 25'(BLINK_HALF - 1);

  logic [1:0]  state, state_nxt;
  logic [7:0]  ring_cnt, ring_cnt_nxt;
  logic [9:0]  snz_cnt, snz_cnt_nxt;
  logic [2:0]  snz_used, snz_used_nxt;
  logic [24:0] blink_cnt, blink_cnt_nxt;
  logic        clk_2_nxt;
  logic        stop_prev, snooze_prev, match_d;
  logic        match, trigger, stop_rise, snooze_rise;

  assign match       = alm_on & (cur_hour == alm_hour) & (cur_min == alm_min) &
                       (cur_sec == 8'h00);
  assign trigger     = match & ~match_d;
  assign stop_rise   = stop_btn & ~stop_prev;
  assign snooze_rise = snooze_btn & ~snooze_prev;

  // Stop/alarm-off outrank snooze, which outranks the seconds countdown.
  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
    snz_cnt_nxt  = snz_cnt;
    snz_used_nxt = snz_used;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          state_nxt    = ST_RING;
          ring_cnt_nxt = RING_INIT;
          snz_used_nxt = '0;
        end
      end
      ST_RING: begin
        if (!alm_on || stop_rise) begin
          state_nxt = ST_IDLE;
        end else if (snooze_rise && (snz_used < SNZ_MAX)) begin
          state_nxt    = ST_SNOOZE;
          snz_cnt_nxt  = SNZ_INIT;
          snz_used_nxt = snz_used + 3'd1;
        end else if (sec_tick) begin
          if (ring_cnt <= 8'd1) state_nxt = ST_IDLE;
          else                  ring_cnt_nxt = ring_cnt - 8'd1;
        end
      end
      ST_SNOOZE: begin
        if (!alm_on || stop_rise) begin
          state_nxt = ST_IDLE;
        end else if (sec_tick) begin
          if (snz_cnt <= 10'd1) begin
            state_nxt    = ST_RING;
            ring_cnt_nxt = RING_INIT;
          end else begin
            snz_cnt_nxt = snz_cnt - 10'd1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Blink runs only while staying in RING; any entry or exit restarts it dark.
  always_comb begin
    blink_cnt_nxt = '0;
    clk_2_nxt     = 1'b0;
    if ((state == ST_RING) && (state_nxt == ST_RING)) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_nxt = '0;
        clk_2_nxt     = ~clk_2;
      end else begin
        blink_cnt_nxt = blink_cnt + 25'd1;
        clk_2_nxt     = clk_2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ring_cnt    <= '0;
      snz_cnt     <= '0;
      snz_used    <= '0;
      blink_cnt   <= '0;
      clk_2       <= 1'b0;
      en          <= 1'b0;
      ringing     <= 1'b0;
      snoozing    <= 1'b0;
      match_d     <= 1'b1;
      stop_prev   <= 1'b1;
      snooze_prev <= 1'b1;
    end else begin
      state       <= state_nxt;
      ring_cnt    <= ring_cnt_nxt;
      snz_cnt     <= snz_cnt_nxt;
      snz_used    <= snz_used_nxt;
      blink_cnt   <= blink_cnt_nxt;
      clk_2       <= clk_2_nxt;
      en          <= (state_nxt == ST_RING);
      ringing     <= (state_nxt == ST_RING);
      snoozing    <= (state_nxt == ST_SNOOZE);
      match_d     <= match;
      stop_prev   <= stop_btn;
      snooze_prev <= snooze_btn;
    end
  end

endmodule
